text_writer: RTL

Character-stream writer for the text-mode display path: accepts byte-wide character codes over a valid/ready handshake, interprets a small set of control codes, and drives the write port of the tile memory that the pixel pipeline reads through `tilemem`. It maintains the text cursor over an 80×60 grid (640×480 at 8×8 glyphs, zoom 0). It also fills the screen with spaces on reset or on form-feed.

---
 rtl/text_writer_pkg.sv | 32 +++
 rtl/text_cursor.sv | 63 ++++++
 rtl/text_writer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/text_writer_pkg.sv
// rtl/text_writer_pkg.sv - shared constants and types for the text-mode character writer
package text_writer_pkg;

  localparam int TEXT_COLS  = 80;
  localparam int TEXT_ROWS  = 60;
  localparam int FONT_WIDTH = 8;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } tw_state_t;

  typedef enum logic [2:0] {
    CUR_HOLD    = 3'd0,
    CUR_ADVANCE = 3'd1,
    CUR_NEWLINE = 3'd2,
    CUR_RETURN  = 3'd3,
    CUR_BACK    = 3'd4,
    CUR_HOME    = 3'd5
  } cursor_op_t;

  function automatic logic is_printable(input logic [7:0] code);
    return (code >= 8'h20) && (code <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// rtl/text_cursor.sv - text cursor: column, row and row_base (row*COLS) kept without a multiplier
module text_cursor
  import text_writer_pkg::*;
#(
  parameter int COLS   = TEXT_COLS,
  parameter int ROWS   = TEXT_ROWS,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rstn,
  input  cursor_op_t        op,
  output logic [6:0]        col,
  output logic [5:0]        row,
  output logic [ADDR_W-1:0] row_base
);

  logic              col_last;
  logic              row_last;
  logic [5:0]        row_nxt;
  logic [ADDR_W-1:0] base_nxt;

  assign col_last = (col == 7'(COLS - 1));
  assign row_last = (row == 6'(ROWS - 1));
  // Row step shared by advance-past-last-column and newline; wraps with no scrolling.
  assign row_nxt  = row_last ? 6'd0 : row + 6'd1;
  assign base_nxt = row_last ? '0 : row_base + ADDR_W'(COLS);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else begin
      case (op)
        CUR_ADVANCE: begin
          if (col_last) begin
            col      <= '0;
            row      <= row_nxt;
            row_base <= base_nxt;
          end else begin
            col <= col + 7'd1;
          end
        end
        CUR_NEWLINE: begin
          col      <= '0;
          row      <= row_nxt;
          row_base <= base_nxt;
        end
        CUR_RETURN: col <= '0;
        CUR_BACK: begin
          if (col != 7'd0) col <= col - 7'd1;
        end
        CUR_HOME: begin
          col      <= '0;
          row      <= '0;
          row_base <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/text_writer.sv
// rtl/text_writer.sv - character stream to tile-memory writer with control codes and screen clear
module text_writer
  import text_writer_pkg::*;
#(
  parameter int COLS           = TEXT_COLS,
  parameter int ROWS           = TEXT_ROWS,
  parameter int CODE_W         = FONT_WIDTH,
  parameter int ADDR_W         = 13,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [CODE_W-1:0] wr_data,
  output logic [6:0]        cursor_col,
  output logic [5:0]        cursor_row,
  output logic              busy
);

  // One spare bit so the sweep counter can reach COLS*ROWS even when it equals 2^ADDR_W.
  localparam int                CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CLR_TOTAL = CNT_W'(COLS * ROWS);
  localparam tw_state_t         ST_RESET  = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
  localparam logic [CODE_W-1:0] SPACE     = CODE_W'(CH_SPACE);

  tw_state_t         state, state_nxt;
  logic [CNT_W-1:0]  clr_cnt, clr_nxt;
  logic              wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [CODE_W-1:0] wr_data_nxt;
  cursor_op_t        cur_op;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] cur_addr;

  text_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk      (clk),
    .rstn     (rstn),
    .op       (cur_op),
    .col      (cursor_col),
    .row      (cursor_row),
    .row_base (row_base)
  );

  assign cur_addr = row_base + ADDR_W'(cursor_col);
  assign in_ready = (state == ST_IDLE);
  assign busy     = (state == ST_CLEAR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_RESET;
      clr_cnt <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_nxt;
      wr_en   <= wr_en_nxt;
      wr_addr <= wr_addr_nxt;
      wr_data <= wr_data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_nxt     = clr_cnt;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    cur_op      = CUR_HOLD;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_printable(in_data)) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = cur_addr;
            wr_data_nxt = CODE_W'(in_data);
            cur_op      = CUR_ADVANCE;
          end else begin
            case (in_data)
              CH_CR: cur_op = CUR_RETURN;
              CH_LF: cur_op = CUR_NEWLINE;
              CH_BS: begin
                if (cursor_col != 7'd0) begin
                  wr_en_nxt   = 1'b1;
                  wr_addr_nxt = cur_addr - ADDR_W'(1);
                  wr_data_nxt = SPACE;
                  cur_op      = CUR_BACK;
                end
              end
              CH_FF: begin
                // Issue address 0 on the accepting edge so writes start the very next cycle.
                state_nxt   = ST_CLEAR;
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = '0;
                wr_data_nxt = SPACE;
                clr_nxt     = CNT_W'(1);
              end
              default: ;
            endcase
          end
        end
      end
      ST_CLEAR: begin
        if (clr_cnt == CLR_TOTAL) begin
          state_nxt = ST_IDLE;
          clr_nxt   = '0;
          cur_op    = CUR_HOME;
        end else begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = clr_cnt[ADDR_W-1:0];
          wr_data_nxt = SPACE;
          clr_nxt     = clr_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule
